axi_wdrop_bresp: RTL and testbench
==================================

Name: axi_wdrop_bresp

Overview:
- Sits directly downstream of the RAB translation/protection FSM, on the write path.
- Consumes the FSM's per-transaction accept/drop pulses and uses them to steer the write-data (W) channel in address order:
  - Beats of accepted bursts go to the master port.
  - Beats of dropped bursts are swallowed.
- Generates the SLVERR B response for each dropped burst and merges it with B responses coming back from the master port.

Parameters:
- AXI_ID_WIDTH, 4, AXI ID width.
- AXI_DATA_WIDTH, 64, W data width; strobe width is AXI_DATA_WIDTH/8.
- AXI_USER_WIDTH, 4, W/B user width.
- FIFO_DEPTH, 4, entries in the decision FIFO and in the drop-response FIFO; power of two, at least 2.

Ports:
- Clk_CI  in  1  clock
- Rst_RI  in  1  reset, asynchronous, active-high
- accept_i  in  1  one-cycle pulse: AW transaction accepted
- drop_i  in  1  one-cycle pulse: AW transaction dropped
- id_i  in  AXI_ID_WIDTH  AW ID; valid with accept_i or drop_i
- full_o  out  1  decision FIFO full; upstream stalls AW while high
- err_overflow_o  out  1  registered pulse: decision lost because FIFO was full
- s_w_valid_i / s_w_ready_o / s_w_last_i  in/out/in  1 each  slave-side W handshake
- s_w_data_i  in  AXI_DATA_WIDTH  slave-side W data
- s_w_strb_i  in  AXI_DATA_WIDTH/8  slave-side W strobe
- s_w_user_i  in  AXI_USER_WIDTH  slave-side W user
- m_w_valid_o / m_w_ready_i / m_w_last_o  out/in/out  1 each  master-side W handshake
- m_w_data_o / m_w_strb_o / m_w_user_o  out  as slave side  master-side W payload
- m_b_valid_i / m_b_ready_o  in/out  1 each  master-side B handshake
- m_b_id_i / m_b_resp_i / m_b_user_i  in  AXI_ID_WIDTH / 2 / AXI_USER_WIDTH  master-side B payload
- s_b_valid_o / s_b_ready_i  out/in  1 each  slave-side B handshake
- s_b_id_o / s_b_resp_o / s_b_user_o  out  AXI_ID_WIDTH / 2 / AXI_USER_WIDTH  slave-side B payload

Behaviour:
- Reset (Rst_RI high, asynchronous): both FIFOs empty, B arbiter in IDLE. full_o=0, err_overflow_o=0, s_b_valid_o=0, m_w_valid_o=0.
- Decision FIFO entry is {drop, id}.
  - Push on accept_i|drop_i.
  - If both are high in the same cycle, the entry is a drop.
  - Push while full (and no pop in the same cycle): entry discarded, err_overflow_o=1 the next cycle.
  - Push while full with a pop in the same cycle: entry accepted.
- full_o = (count==FIFO_DEPTH), registered count.
- W routing is combinational on the FIFO head.
  - Empty FIFO: s_w_ready_o=0, m_w_valid_o=0.
  - Head is accept:
    - m_w_valid_o=s_w_valid_i; s_w_ready_o=m_w_ready_i.
    - Payload and last pass through unchanged.
    - Pop on handshake with s_w_last_i=1.
  - Head is drop:
    - m_w_valid_o=0; s_w_ready_o=1 for non-last beats.
    - For the last beat, s_w_ready_o=~resp_fifo_full.
    - On the last-beat handshake: pop decision, push the id into the drop-response FIFO.
- W-channel latency is zero (combinational pass-through); a decision pushed in cycle N is usable at the head from cycle N+1.
- B arbiter, registered select with states IDLE, MST, DRP:
  - IDLE -> MST if m_b_valid_i (master responses have priority).
  - IDLE -> DRP if the drop-response FIFO is non-empty and m_b_valid_i=0.
  - MST: s_b_* = m_b_*, m_b_ready_o=s_b_ready_i. Return to IDLE on handshake.
  - DRP: s_b_valid_o=1, s_b_id_o=FIFO head, s_b_resp_o=2'b10 (SLVERR), s_b_user_o='0, m_b_ready_o=0. Pop and return to IDLE on handshake.
  - In IDLE: s_b_valid_o=0, m_b_ready_o=0.
  - The lock guarantees s_b_* stays stable while s_b_valid_o=1 and s_b_ready_i=0.
- Minimum latency from dropped last-beat handshake to s_b_valid_o is 2 cycles (FIFO write, then arbiter state).
- Reset mid-burst: all pending decisions and responses are discarded; upstream is also reset.

Decomposition:
- Package axi_wdrop_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Struct decision_t {drop, id}.
  - Enum b_sel_e {IDLE, MST, DRP}.
- Sub-module wdrop_fifo:
  - Generic synchronous FIFO with parameterised type/depth, full/empty, count.
  - Instantiated twice: decision FIFO and drop-response FIFO.

Test Plan:
- Accept id=3, 4-beat burst, m_w_ready_i=1 -> 4 beats on m_w with last on beat 4; decision FIFO empty afterwards; s_b passes master B{id=3, OKAY}.
- Drop id=5, 2-beat burst -> m_w_valid_o never 1; s_w_ready_o=1 on both beats; s_b_valid_o 2 cycles after the last beat with id=5, resp=2'b10, user=0.
- Sequence accept id=1 (3 beats), drop id=2 (1 beat), accept id=4 (2 beats) -> m_w sees exactly 5 beats in order; only one SLVERR with id=2.
- m_b_valid_i and a pending drop response in the same cycle, s_b_ready_i low for 3 cycles -> master B selected first and held stable; drop B follows after the handshake.
- Five drop_i pulses with no W traffic, FIFO_DEPTH=4 -> full_o=1 after the 4th pulse; err_overflow_o pulses once; only 4 entries retained.
- Rst_RI asserted mid-burst -> all outputs 0 immediately; after release a new accept burst routes correctly.

Source files
------------

// File: rtl/axi_wdrop_bresp_pkg.sv
// Shared types and constants for the write-drop / B-response merge block.
//   RESP_OKAY / RESP_SLVERR : AXI B response codes used by the block
//   ID_W                    : AXI ID width carried in decision entries
//   decision_t              : per-transaction steering decision {drop, id}
//   b_sel_e                 : B-channel arbiter select state
package axi_wdrop_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // decision_t is sized from this constant; the top's AXI_ID_WIDTH defaults to it.
    localparam int ID_W = 4;

    typedef struct packed {
        logic            drop;
        logic [ID_W-1:0] id;
    } decision_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MST  = 2'd1,
        DRP  = 2'd2
    } b_sel_e;

endpackage

// File: rtl/axi_wdrop_bresp_if.sv
// AXI W + B channel bundle.
//   master modport : drives W payload/valid and B ready, receives W ready and B payload/valid
//   slave  modport : the mirror image
interface axi_wdrop_bresp_if #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 64,
    parameter int USER_W = 4
);
    logic                w_valid;
    logic                w_ready;
    logic                w_last;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic [USER_W-1:0]   w_user;

    logic                b_valid;
    logic                b_ready;
    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic [USER_W-1:0]   b_user;

    modport master (
        output w_valid, w_last, w_data, w_strb, w_user, b_ready,
        input  w_ready, b_valid, b_id, b_resp, b_user
    );

    modport slave (
        input  w_valid, w_last, w_data, w_strb, w_user, b_ready,
        output w_ready, b_valid, b_id, b_resp, b_user
    );
endinterface

// File: rtl/axi_wdrop_bresp_fifo.sv
// Generic synchronous FIFO (first-word fall-through read port).
//   clk_i/rst_i : clock, asynchronous active-high reset
//   push_i/data_i : write; ignored while full unless a pop happens the same cycle
//   pop_i/data_o  : read; data_o is the current head, pop ignored while empty
//   full_o / count_o : status from the registered occupancy
module wdrop_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output T                       data_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i && (count_q != '0);
    // A pop frees the slot in the same cycle, so a push into a full FIFO is taken then.
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push_s) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axi_wdrop_bresp.sv
// Write-path drop filter and B-response merger behind the RAB translation FSM.
//   Clk_CI, Rst_RI      : clock, asynchronous active-high reset
//   accept_i/drop_i/id_i: per-AW decision pulses and the AW ID
//   full_o              : decision FIFO full (upstream stalls AW)
//   err_overflow_o      : registered pulse, a decision was lost to a full FIFO
//   slv                 : upstream W/B (slave side)
//   mst                 : downstream W/B (master side)
// W beats follow decisions in address order: accepted bursts pass through
// combinationally, dropped bursts are swallowed and queue a SLVERR response
// that is merged with master-port B responses by a locking arbiter.
module axi_wdrop_bresp
    import axi_wdrop_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = ID_W,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RI,
    input  logic                    accept_i,
    input  logic                    drop_i,
    input  logic [AXI_ID_WIDTH-1:0] id_i,
    output logic                    full_o,
    output logic                    err_overflow_o,
    axi_wdrop_bresp_if.slave        slv,
    axi_wdrop_bresp_if.master       mst
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    decision_t               dec_in_s;
    decision_t               dec_head_s;
    logic                    dec_push_s;
    logic                    dec_pop_s;
    logic                    dec_full_s;
    logic [CW-1:0]           dec_count_s;
    logic                    dec_empty_s;

    logic [AXI_ID_WIDTH-1:0] resp_head_s;
    logic                    resp_push_s;
    logic                    resp_pop_s;
    logic                    resp_full_s;
    logic [CW-1:0]           resp_count_s;
    logic                    resp_empty_s;

    logic                    s_w_ready_s;
    logic                    err_overflow_q;
    b_sel_e                  state_q;
    b_sel_e                  state_d;

    // A simultaneous accept and drop is recorded as a drop.
    assign dec_in_s.drop = drop_i;
    assign dec_in_s.id   = id_i;
    assign dec_push_s    = accept_i | drop_i;
    assign dec_empty_s   = (dec_count_s == '0);
    assign resp_empty_s  = (resp_count_s == '0);
    assign full_o        = dec_full_s;
    assign err_overflow_o = err_overflow_q;

    wdrop_fifo #(.T(decision_t), .DEPTH(FIFO_DEPTH)) u_dec_fifo (
        .clk_i   (Clk_CI),
        .rst_i   (Rst_RI),
        .push_i  (dec_push_s),
        .data_i  (dec_in_s),
        .pop_i   (dec_pop_s),
        .data_o  (dec_head_s),
        .full_o  (dec_full_s),
        .count_o (dec_count_s)
    );

    wdrop_fifo #(.T(logic [AXI_ID_WIDTH-1:0]), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
        .clk_i   (Clk_CI),
        .rst_i   (Rst_RI),
        .push_i  (resp_push_s),
        .data_i  (dec_head_s.id),
        .pop_i   (resp_pop_s),
        .data_o  (resp_head_s),
        .full_o  (resp_full_s),
        .count_o (resp_count_s)
    );

    // W payload always passes through; only valid/ready are steered.
    assign mst.w_data = slv.w_data;
    assign mst.w_strb = slv.w_strb;
    assign mst.w_user = slv.w_user;
    assign mst.w_last = slv.w_last;
    assign slv.w_ready = s_w_ready_s;

    // W steering from the decision FIFO head.
    always_comb begin
        mst.w_valid  = 1'b0;
        s_w_ready_s  = 1'b0;
        dec_pop_s    = 1'b0;
        resp_push_s  = 1'b0;
        if (dec_empty_s) begin
            s_w_ready_s = 1'b0;
        end else if (!dec_head_s.drop) begin
            mst.w_valid = slv.w_valid;
            s_w_ready_s = mst.w_ready;
            dec_pop_s   = slv.w_valid && mst.w_ready && slv.w_last;
        end else begin
            // The last beat of a dropped burst waits for room to queue its SLVERR.
            s_w_ready_s = slv.w_last ? ~resp_full_s : 1'b1;
            dec_pop_s   = slv.w_valid && s_w_ready_s && slv.w_last;
            resp_push_s = dec_pop_s;
        end
    end

    // Overflow flag: a push into a full FIFO that no same-cycle pop rescues.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) err_overflow_q <= 1'b0;
        else        err_overflow_q <= dec_push_s & dec_full_s & ~dec_pop_s;
    end

    // B arbiter select register.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // B arbiter next state and output mux; the select holds until handshake.
    always_comb begin
        state_d     = state_q;
        slv.b_valid = 1'b0;
        slv.b_id    = '0;
        slv.b_resp  = RESP_OKAY;
        slv.b_user  = '0;
        mst.b_ready = 1'b0;
        resp_pop_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mst.b_valid)        state_d = MST;
                else if (!resp_empty_s) state_d = DRP;
                else                    state_d = IDLE;
            end
            MST: begin
                slv.b_valid = mst.b_valid;
                slv.b_id    = mst.b_id;
                slv.b_resp  = mst.b_resp;
                slv.b_user  = mst.b_user;
                mst.b_ready = slv.b_ready;
                if (mst.b_valid && slv.b_ready) state_d = IDLE;
                else                            state_d = MST;
            end
            DRP: begin
                slv.b_valid = 1'b1;
                slv.b_id    = resp_head_s;
                slv.b_resp  = RESP_SLVERR;
                resp_pop_s  = slv.b_ready;
                if (slv.b_ready) state_d = IDLE;
                else             state_d = DRP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_wdrop_bresp.sv
module tb_axi_wdrop_bresp;

    logic       Clk_CI;
    logic       Rst_RI;
    logic       accept_i;
    logic       drop_i;
    logic [3:0] id_i;
    logic       full_o;
    logic       err_overflow_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    axi_wdrop_bresp_if #(.ID_W(4), .DATA_W(64), .USER_W(4)) slv_if ();
    axi_wdrop_bresp_if #(.ID_W(4), .DATA_W(64), .USER_W(4)) mst_if ();

    axi_wdrop_bresp #(
        .AXI_ID_WIDTH(4), .AXI_DATA_WIDTH(64), .AXI_USER_WIDTH(4), .FIFO_DEPTH(4)
    ) dut (
        .Clk_CI(Clk_CI), .Rst_RI(Rst_RI),
        .accept_i(accept_i), .drop_i(drop_i), .id_i(id_i),
        .full_o(full_o), .err_overflow_o(err_overflow_o),
        .slv(slv_if), .mst(mst_if)
    );

    initial Clk_CI = 1'b0;
    always #5 Clk_CI = ~Clk_CI;

    task automatic tick();
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic pulse(input logic a, input logic d, input logic [3:0] id);
        accept_i = a; drop_i = d; id_i = id;
        tick();
        accept_i = 1'b0; drop_i = 1'b0;
    endtask

    task automatic test_reset();
        Rst_RI = 1'b1;
        #1;
        total_cnt++; if (full_o !== 1'b0) $display("FAIL rst_full: got %0h expected 0", full_o); else pass_cnt++;
        total_cnt++; if (err_overflow_o !== 1'b0) $display("FAIL rst_err: got %0h expected 0", err_overflow_o); else pass_cnt++;
        total_cnt++; if (slv_if.b_valid !== 1'b0) $display("FAIL rst_bvalid: got %0h expected 0", slv_if.b_valid); else pass_cnt++;
        total_cnt++; if (mst_if.w_valid !== 1'b0) $display("FAIL rst_mwvalid: got %0h expected 0", mst_if.w_valid); else pass_cnt++;
        total_cnt++; if (slv_if.w_ready !== 1'b0) $display("FAIL rst_swready: got %0h expected 0", slv_if.w_ready); else pass_cnt++;
        tick(); tick();
        Rst_RI = 1'b0;
        tick();
    endtask

    task automatic test_accept();
        pulse(1'b1, 1'b0, 4'd3);
        mst_if.w_ready = 1'b0;
        slv_if.w_valid = 1'b1; slv_if.w_data = 64'hA000; slv_if.w_last = 1'b0;
        #1;
        total_cnt++; if (slv_if.w_ready !== 1'b0) $display("FAIL acc_backpress: got %0h expected 0", slv_if.w_ready); else pass_cnt++;
        mst_if.w_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            slv_if.w_valid = 1'b1;
            slv_if.w_data  = 64'hA000 + 64'(k);
            slv_if.w_strb  = 8'hF0 | 8'(k);
            slv_if.w_user  = 4'(k + 1);
            slv_if.w_last  = (k == 3);
            #1;
            total_cnt++; if (mst_if.w_valid !== 1'b1) $display("FAIL acc_mvalid: got %0h expected 1", mst_if.w_valid); else pass_cnt++;
            total_cnt++; if (mst_if.w_data !== 64'hA000 + 64'(k)) $display("FAIL acc_data: got %0h expected %0h", mst_if.w_data, 64'hA000 + 64'(k)); else pass_cnt++;
            total_cnt++; if (mst_if.w_strb !== (8'hF0 | 8'(k))) $display("FAIL acc_strb: got %0h expected %0h", mst_if.w_strb, 8'hF0 | 8'(k)); else pass_cnt++;
            total_cnt++; if (mst_if.w_last !== (k == 3)) $display("FAIL acc_last: got %0h expected %0h", mst_if.w_last, (k == 3)); else pass_cnt++;
            total_cnt++; if (slv_if.w_ready !== 1'b1) $display("FAIL acc_sready: got %0h expected 1", slv_if.w_ready); else pass_cnt++;
            tick();
        end
        slv_if.w_valid = 1'b0; slv_if.w_last = 1'b0;
        #1;
        total_cnt++; if (slv_if.w_ready !== 1'b0) $display("FAIL acc_empty_after: got %0h expected 0", slv_if.w_ready); else pass_cnt++;
        slv_if.b_ready = 1'b1;
        mst_if.b_valid = 1'b1; mst_if.b_id = 4'd3; mst_if.b_resp = 2'b00; mst_if.b_user = 4'h5;
        tick();
        total_cnt++; if (slv_if.b_valid !== 1'b1) $display("FAIL acc_bvalid: got %0h expected 1", slv_if.b_valid); else pass_cnt++;
        total_cnt++; if (slv_if.b_id !== 4'd3) $display("FAIL acc_bid: got %0h expected 3", slv_if.b_id); else pass_cnt++;
        total_cnt++; if (slv_if.b_resp !== 2'b00) $display("FAIL acc_bresp: got %0h expected 0", slv_if.b_resp); else pass_cnt++;
        total_cnt++; if (slv_if.b_user !== 4'h5) $display("FAIL acc_buser: got %0h expected 5", slv_if.b_user); else pass_cnt++;
        total_cnt++; if (mst_if.b_ready !== 1'b1) $display("FAIL acc_mbready: got %0h expected 1", mst_if.b_ready); else pass_cnt++;
        tick();
        mst_if.b_valid = 1'b0;
        #1;
        total_cnt++; if (slv_if.b_valid !== 1'b0) $display("FAIL acc_bidle: got %0h expected 0", slv_if.b_valid); else pass_cnt++;
    endtask

    task automatic test_drop();
        slv_if.b_ready = 1'b0;
        pulse(1'b0, 1'b1, 4'd5);
        for (int k = 0; k < 2; k++) begin
            slv_if.w_valid = 1'b1; slv_if.w_last = (k == 1); slv_if.w_data = 64'hD000 + 64'(k);
            #1;
            total_cnt++; if (mst_if.w_valid !== 1'b0) $display("FAIL drop_mvalid: got %0h expected 0", mst_if.w_valid); else pass_cnt++;
            total_cnt++; if (slv_if.w_ready !== 1'b1) $display("FAIL drop_sready: got %0h expected 1", slv_if.w_ready); else pass_cnt++;
            tick();
        end
        slv_if.w_valid = 1'b0; slv_if.w_last = 1'b0;
        total_cnt++; if (slv_if.b_valid !== 1'b0) $display("FAIL drop_b_early: got %0h expected 0", slv_if.b_valid); else pass_cnt++;
        tick();
        total_cnt++; if (slv_if.b_valid !== 1'b1) $display("FAIL drop_bvalid: got %0h expected 1", slv_if.b_valid); else pass_cnt++;
        total_cnt++; if (slv_if.b_id !== 4'd5) $display("FAIL drop_bid: got %0h expected 5", slv_if.b_id); else pass_cnt++;
        total_cnt++; if (slv_if.b_resp !== 2'b10) $display("FAIL drop_bresp: got %0h expected 2", slv_if.b_resp); else pass_cnt++;
        total_cnt++; if (slv_if.b_user !== 4'h0) $display("FAIL drop_buser: got %0h expected 0", slv_if.b_user); else pass_cnt++;
        total_cnt++; if (mst_if.b_ready !== 1'b0) $display("FAIL drop_mbready: got %0h expected 0", mst_if.b_ready); else pass_cnt++;
        slv_if.b_ready = 1'b1;
        tick();
        #1;
        total_cnt++; if (slv_if.b_valid !== 1'b0) $display("FAIL drop_b_done: got %0h expected 0", slv_if.b_valid); else pass_cnt++;
    endtask

    task automatic test_sequence();
        logic [63:0] exp_d [5];
        logic        last_tab [6];
        int          mbeat = 0;
        int          nerr  = 0;
        logic [3:0]  err_id = 4'h0;
        exp_d    = '{64'h2000, 64'h2001, 64'h2002, 64'h2004, 64'h2005};
        last_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        slv_if.b_ready = 1'b1;
        mst_if.w_ready = 1'b1;
        pulse(1'b1, 1'b0, 4'd1);
        pulse(1'b0, 1'b1, 4'd2);
        pulse(1'b1, 1'b0, 4'd4);
        for (int i = 0; i < 12; i++) begin
            if (i < 6) begin
                slv_if.w_valid = 1'b1; slv_if.w_data = 64'h2000 + 64'(i); slv_if.w_last = last_tab[i];
            end else begin
                slv_if.w_valid = 1'b0; slv_if.w_last = 1'b0;
            end
            #1;
            if (mst_if.w_valid && mst_if.w_ready) begin
                if (mbeat < 5) begin
                    total_cnt++; if (mst_if.w_data !== exp_d[mbeat]) $display("FAIL seq_data: got %0h expected %0h", mst_if.w_data, exp_d[mbeat]); else pass_cnt++;
                end
                mbeat++;
            end
            if (slv_if.b_valid && slv_if.b_ready) begin
                nerr++;
                err_id = slv_if.b_id;
                total_cnt++; if (slv_if.b_resp !== 2'b10) $display("FAIL seq_bresp: got %0h expected 2", slv_if.b_resp); else pass_cnt++;
            end
            tick();
        end
        total_cnt++; if (mbeat !== 5) $display("FAIL seq_beats: got %0d expected 5", mbeat); else pass_cnt++;
        total_cnt++; if (nerr !== 1) $display("FAIL seq_nerr: got %0d expected 1", nerr); else pass_cnt++;
        total_cnt++; if (err_id !== 4'd2) $display("FAIL seq_err_id: got %0h expected 2", err_id); else pass_cnt++;
    endtask

    task automatic test_arb();
        slv_if.b_ready = 1'b0;
        pulse(1'b0, 1'b1, 4'd6);
        slv_if.w_valid = 1'b1; slv_if.w_last = 1'b1;
        tick();
        slv_if.w_valid = 1'b0; slv_if.w_last = 1'b0;
        mst_if.b_valid = 1'b1; mst_if.b_id = 4'd7; mst_if.b_resp = 2'b00; mst_if.b_user = 4'h3;
        tick();
        for (int k = 0; k < 3; k++) begin
            total_cnt++; if (slv_if.b_valid !== 1'b1) $display("FAIL arb_hold_valid: got %0h expected 1", slv_if.b_valid); else pass_cnt++;
            total_cnt++; if (slv_if.b_id !== 4'd7) $display("FAIL arb_hold_id: got %0h expected 7", slv_if.b_id); else pass_cnt++;
            total_cnt++; if (slv_if.b_resp !== 2'b00) $display("FAIL arb_hold_resp: got %0h expected 0", slv_if.b_resp); else pass_cnt++;
            total_cnt++; if (slv_if.b_user !== 4'h3) $display("FAIL arb_hold_user: got %0h expected 3", slv_if.b_user); else pass_cnt++;
            tick();
        end
        slv_if.b_ready = 1'b1;
        #1;
        total_cnt++; if (mst_if.b_ready !== 1'b1) $display("FAIL arb_mbready: got %0h expected 1", mst_if.b_ready); else pass_cnt++;
        tick();
        mst_if.b_valid = 1'b0;
        #1;
        total_cnt++; if (slv_if.b_valid !== 1'b0) $display("FAIL arb_idle: got %0h expected 0", slv_if.b_valid); else pass_cnt++;
        tick();
        total_cnt++; if (slv_if.b_valid !== 1'b1) $display("FAIL arb_drp_valid: got %0h expected 1", slv_if.b_valid); else pass_cnt++;
        total_cnt++; if (slv_if.b_id !== 4'd6) $display("FAIL arb_drp_id: got %0h expected 6", slv_if.b_id); else pass_cnt++;
        total_cnt++; if (slv_if.b_resp !== 2'b10) $display("FAIL arb_drp_resp: got %0h expected 2", slv_if.b_resp); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (slv_if.b_valid !== 1'b0) $display("FAIL arb_done: got %0h expected 0", slv_if.b_valid); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int         nr = 0;
        logic [3:0] got [8];
        slv_if.b_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drop_i = 1'b1; id_i = 4'(8 + k);
            tick();
            total_cnt++; if (full_o !== (k >= 3)) $display("FAIL ovf_full: got %0h expected %0h", full_o, (k >= 3)); else pass_cnt++;
            total_cnt++; if (err_overflow_o !== (k == 4)) $display("FAIL ovf_err: got %0h expected %0h", err_overflow_o, (k == 4)); else pass_cnt++;
        end
        drop_i = 1'b0;
        tick();
        total_cnt++; if (err_overflow_o !== 1'b0) $display("FAIL ovf_err_once: got %0h expected 0", err_overflow_o); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            slv_if.w_valid = 1'b1; slv_if.w_last = 1'b1;
            #1;
            total_cnt++; if (slv_if.w_ready !== 1'b1) $display("FAIL ovf_drain_ready: got %0h expected 1", slv_if.w_ready); else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (slv_if.w_ready !== 1'b0) $display("FAIL ovf_only4: got %0h expected 0", slv_if.w_ready); else pass_cnt++;
        total_cnt++; if (full_o !== 1'b0) $display("FAIL ovf_full_after: got %0h expected 0", full_o); else pass_cnt++;
        slv_if.w_valid = 1'b0; slv_if.w_last = 1'b0;
        slv_if.b_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (slv_if.b_valid && slv_if.b_ready) begin
                if (nr < 8) got[nr] = slv_if.b_id;
                nr++;
            end
            tick();
        end
        total_cnt++; if (nr !== 4) $display("FAIL ovf_nresp: got %0d expected 4", nr); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++; if (got[k] !== 4'(8 + k)) $display("FAIL ovf_resp_id: got %0h expected %0h", got[k], 4'(8 + k)); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        mst_if.w_ready = 1'b1;
        slv_if.b_ready = 1'b0;
        pulse(1'b1, 1'b0, 4'd1);
        slv_if.w_valid = 1'b1; slv_if.w_last = 1'b0; slv_if.w_data = 64'h1111;
        #1;
        total_cnt++; if (mst_if.w_valid !== 1'b1) $display("FAIL rmid_pre_mvalid: got %0h expected 1", mst_if.w_valid); else pass_cnt++;
        tick();
        mst_if.b_valid = 1'b1; mst_if.b_id = 4'd1; mst_if.b_resp = 2'b00;
        tick();
        total_cnt++; if (slv_if.b_valid !== 1'b1) $display("FAIL rmid_pre_bvalid: got %0h expected 1", slv_if.b_valid); else pass_cnt++;
        Rst_RI = 1'b1;
        #1;
        total_cnt++; if (mst_if.w_valid !== 1'b0) $display("FAIL rmid_mvalid: got %0h expected 0", mst_if.w_valid); else pass_cnt++;
        total_cnt++; if (slv_if.w_ready !== 1'b0) $display("FAIL rmid_sready: got %0h expected 0", slv_if.w_ready); else pass_cnt++;
        total_cnt++; if (slv_if.b_valid !== 1'b0) $display("FAIL rmid_bvalid: got %0h expected 0", slv_if.b_valid); else pass_cnt++;
        total_cnt++; if (full_o !== 1'b0) $display("FAIL rmid_full: got %0h expected 0", full_o); else pass_cnt++;
        tick();
        Rst_RI = 1'b0;
        mst_if.b_valid = 1'b0;
        slv_if.w_valid = 1'b0;
        tick();
        pulse(1'b1, 1'b0, 4'd9);
        slv_if.w_valid = 1'b1; slv_if.w_last = 1'b1; slv_if.w_data = 64'hBEEF;
        #1;
        total_cnt++; if (mst_if.w_valid !== 1'b1) $display("FAIL rmid_post_mvalid: got %0h expected 1", mst_if.w_valid); else pass_cnt++;
        total_cnt++; if (mst_if.w_data !== 64'hBEEF) $display("FAIL rmid_post_data: got %0h expected beef", mst_if.w_data); else pass_cnt++;
        total_cnt++; if (mst_if.w_last !== 1'b1) $display("FAIL rmid_post_last: got %0h expected 1", mst_if.w_last); else pass_cnt++;
        tick();
        slv_if.w_valid = 1'b0; slv_if.w_last = 1'b0;
        #1;
        total_cnt++; if (slv_if.w_ready !== 1'b0) $display("FAIL rmid_post_empty: got %0h expected 0", slv_if.w_ready); else pass_cnt++;
    endtask

    initial begin
        Rst_RI = 1'b1; accept_i = 1'b0; drop_i = 1'b0; id_i = 4'h0;
        slv_if.w_valid = 1'b0; slv_if.w_last = 1'b0; slv_if.w_data = 64'h0;
        slv_if.w_strb = 8'h00; slv_if.w_user = 4'h0; slv_if.b_ready = 1'b0;
        mst_if.w_ready = 1'b0; mst_if.b_valid = 1'b0; mst_if.b_id = 4'h0;
        mst_if.b_resp = 2'b00; mst_if.b_user = 4'h0;
        test_reset();
        test_accept();
        test_drop();
        test_sequence();
        test_arb();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
